// File: rtl/perf_event_counter_bank.sv
// Bank of performance-event counters with optional sampling windows.
// Snapshots of all channels are streamed out one channel per valid/ready beat.
`timescale 1ns/1ps

module perf_event_counter_bank #(
  parameter int CHANNELS     = 8,
  parameter int CNT_WIDTH    = 32,
  parameter int INC_WIDTH    = 3,
  parameter int WINDOW_WIDTH = 16,
  parameter int SATURATE     = 1,
  localparam int IdWidth     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CHANNELS*INC_WIDTH-1:0] event_inc,
  input  logic                          enable,
  input  logic                          clear,
  input  logic [WINDOW_WIDTH-1:0]       window_cfg,
  input  logic                          dump_req,
  output logic                          dump_valid,
  input  logic                          dump_ready,
  output logic [IdWidth-1:0]            dump_id,
  output logic [CNT_WIDTH-1:0]          dump_data,
  output logic                          dump_ovf,
  output logic                          dump_last,
  output logic                          busy,
  output logic                          snap_drop
);

  localparam logic [IdWidth-1:0] LastIdx = IdWidth'(CHANNELS - 1);

  typedef enum logic {Idle, Dump} state_t;

  state_t                  state;
  logic [CNT_WIDTH-1:0]    cnt     [CHANNELS];
  logic [CNT_WIDTH-1:0]    nextCnt [CHANNELS];
  logic [CNT_WIDTH-1:0]    shadow  [CHANNELS];
  logic [CNT_WIDTH:0]      sum     [CHANNELS];
  logic [CHANNELS-1:0]     ovf;
  logic [CHANNELS-1:0]     nextOvf;
  logic [CHANNELS-1:0]     shadowOvf;
  logic [WINDOW_WIDTH-1:0] windowCnt;
  logic [WINDOW_WIDTH-1:0] windowLast;
  logic                    windowOn;
  logic                    boundary;
  logic                    trigger;
  logic [IdWidth-1:0]      nextIdx;

  // One extra bit on each sum exposes the carry that marks an overflow.
  for (genvar i = 0; i < CHANNELS; i++) begin : gSum
    assign sum[i] = {1'b0, cnt[i]} + (CNT_WIDTH+1)'(event_inc[i*INC_WIDTH +: INC_WIDTH]);
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      nextCnt[i] = cnt[i];
      nextOvf[i] = ovf[i];
      if (enable) begin
        nextCnt[i] = sum[i][CNT_WIDTH-1:0];
        if (sum[i][CNT_WIDTH]) begin
          nextOvf[i] = 1'b1;
          if (SATURATE != 0) nextCnt[i] = '1;
        end
      end
    end
  end

  // Comparing with >= lets a shrunken window length close the window at once.
  assign windowOn   = (window_cfg != '0);
  assign windowLast = window_cfg - 1'b1;
  assign boundary   = enable && windowOn && (windowCnt >= windowLast);
  assign trigger    = boundary || dump_req;
  assign nextIdx    = dump_id + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
      ovf       <= '0;
      windowCnt <= '0;
    end else if (clear || boundary) begin
      for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
      ovf       <= '0;
      windowCnt <= '0;
    end else begin
      cnt <= nextCnt;
      ovf <= nextOvf;
      if (enable && windowOn) windowCnt <= windowCnt + 1'b1;
    end
  end

  // Shadows are only written from Idle, so a running dump never sees them change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= Idle;
      for (int i = 0; i < CHANNELS; i++) shadow[i] <= '0;
      shadowOvf  <= '0;
      dump_valid <= 1'b0;
      dump_id    <= '0;
      dump_data  <= '0;
      dump_ovf   <= 1'b0;
      dump_last  <= 1'b0;
      busy       <= 1'b0;
      snap_drop  <= 1'b0;
    end else begin
      snap_drop <= 1'b0;
      case (state)
        Idle: begin
          if (trigger) begin
            shadow     <= nextCnt;
            shadowOvf  <= nextOvf;
            dump_valid <= 1'b1;
            busy       <= 1'b1;
            dump_id    <= '0;
            dump_data  <= nextCnt[0];
            dump_ovf   <= nextOvf[0];
            dump_last  <= (CHANNELS == 1);
            state      <= Dump;
          end
        end
        Dump: begin
          if (trigger) snap_drop <= 1'b1;
          if (dump_ready) begin
            if (dump_last) begin
              dump_valid <= 1'b0;
              busy       <= 1'b0;
              dump_last  <= 1'b0;
              state      <= Idle;
            end else begin
              dump_id   <= nextIdx;
              dump_data <= shadow[nextIdx];
              dump_ovf  <= shadowOvf[nextIdx];
              dump_last <= (nextIdx == LastIdx);
            end
          end
        end
        default: state <= Idle;
      endcase
    end
  end

endmodule

// File: tb/tb_perf_event_counter_bank.sv
// Randomised bench for perf_event_counter_bank: a saturating and a wrapping
// instance share stimulus and are compared with a queue-based reference model.
`timescale 1ns/1ps

module tb_perf_event_counter_bank;

  localparam int Ch   = 8;
  localparam int Cw   = 8;
  localparam int Iw   = 3;
  localparam int Ww   = 16;
  localparam int CMax = (1 << Cw) - 1;

  typedef struct {
    int id;
    int data;
    bit ovf;
    bit last;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [Ch*Iw-1:0] eventInc = '0;
  logic             enable = 1'b0;
  logic             clear = 1'b0;
  logic [Ww-1:0]    windowCfg = '0;
  logic             dumpReq = 1'b0;
  logic             dumpReady = 1'b0;

  logic             dumpValid [2];
  logic [2:0]       dumpId    [2];
  logic [Cw-1:0]    dumpData  [2];
  logic             dumpOvf   [2];
  logic             dumpLast  [2];
  logic             busy      [2];
  logic             snapDrop  [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  perf_event_counter_bank #(.CHANNELS(Ch), .CNT_WIDTH(Cw), .INC_WIDTH(Iw),
                            .WINDOW_WIDTH(Ww), .SATURATE(1)) dutSat (
    .clk(clk), .rst(rst), .event_inc(eventInc), .enable(enable), .clear(clear),
    .window_cfg(windowCfg), .dump_req(dumpReq), .dump_valid(dumpValid[0]),
    .dump_ready(dumpReady), .dump_id(dumpId[0]), .dump_data(dumpData[0]),
    .dump_ovf(dumpOvf[0]), .dump_last(dumpLast[0]), .busy(busy[0]),
    .snap_drop(snapDrop[0]));

  perf_event_counter_bank #(.CHANNELS(Ch), .CNT_WIDTH(Cw), .INC_WIDTH(Iw),
                            .WINDOW_WIDTH(Ww), .SATURATE(0)) dutWrap (
    .clk(clk), .rst(rst), .event_inc(eventInc), .enable(enable), .clear(clear),
    .window_cfg(windowCfg), .dump_req(dumpReq), .dump_valid(dumpValid[1]),
    .dump_ready(dumpReady), .dump_id(dumpId[1]), .dump_data(dumpData[1]),
    .dump_ovf(dumpOvf[1]), .dump_last(dumpLast[1]), .busy(busy[1]),
    .snap_drop(snapDrop[1]));

  task automatic checkOutput(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: index 0 saturates, index 1 wraps.
  int    mCnt  [2][Ch];
  bit    mOvf  [2][Ch];
  int    nxt   [2][Ch];
  bit    nOvf  [2][Ch];
  bit    mDrop [2];
  int    mWin;
  beat_t qSat[$];
  beat_t qWrap[$];
  bit    mBoundary;
  bit    mTrigger;
  bit    mBusy;
  int    s;
  beat_t b;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int m = 0; m < 2; m++) begin
        for (int c = 0; c < Ch; c++) begin
          mCnt[m][c] = 0;
          mOvf[m][c] = 1'b0;
        end
        mDrop[m] = 1'b0;
      end
      mWin = 0;
      qSat.delete();
      qWrap.delete();
    end else begin
      mBoundary = enable && (windowCfg != 0) && (mWin >= int'(windowCfg) - 1);
      mTrigger  = mBoundary || dumpReq;
      for (int m = 0; m < 2; m++) begin
        mBusy = (m == 0) ? (qSat.size() != 0) : (qWrap.size() != 0);
        if (mBusy && dumpReady) begin
          if (m == 0) void'(qSat.pop_front());
          else void'(qWrap.pop_front());
        end
        for (int c = 0; c < Ch; c++) begin
          nxt[m][c]  = mCnt[m][c];
          nOvf[m][c] = mOvf[m][c];
          if (enable) begin
            s = mCnt[m][c] + int'(eventInc[c*Iw +: Iw]);
            if (s > CMax) begin
              nOvf[m][c] = 1'b1;
              nxt[m][c]  = (m == 0) ? CMax : s - (CMax + 1);
            end else begin
              nxt[m][c] = s;
            end
          end
        end
        mDrop[m] = mTrigger && mBusy;
        if (mTrigger && !mBusy) begin
          for (int c = 0; c < Ch; c++) begin
            b.id = c; b.data = nxt[m][c]; b.ovf = nOvf[m][c]; b.last = (c == Ch - 1);
            if (m == 0) qSat.push_back(b);
            else qWrap.push_back(b);
          end
        end
        for (int c = 0; c < Ch; c++) begin
          mCnt[m][c] = (clear || mBoundary) ? 0 : nxt[m][c];
          mOvf[m][c] = (clear || mBoundary) ? 1'b0 : nOvf[m][c];
        end
      end
      if (clear || mBoundary) mWin = 0;
      else if (enable && windowCfg != 0) mWin = mWin + 1;
    end
  end

  // Every falling edge out of reset compares both instances with the model.
  string nm [2] = '{"sat", "wrap"};
  bit    expValid;
  beat_t f;
  always @(negedge clk) begin
    if (rst) begin
      for (int m = 0; m < 2; m++) begin
        expValid = (m == 0) ? (qSat.size() != 0) : (qWrap.size() != 0);
        checkOutput({nm[m], ".valid"}, dumpValid[m], expValid);
        checkOutput({nm[m], ".busy"}, busy[m], expValid);
        checkOutput({nm[m], ".snapDrop"}, snapDrop[m], mDrop[m]);
        if (expValid) begin
          f = (m == 0) ? qSat[0] : qWrap[0];
          checkOutput({nm[m], ".id"}, dumpId[m], f.id);
          checkOutput({nm[m], ".data"}, dumpData[m], f.data);
          checkOutput({nm[m], ".ovf"}, dumpOvf[m], f.ovf);
          checkOutput({nm[m], ".last"}, dumpLast[m], f.last);
        end
      end
    end
  end

  function automatic logic [Ch*Iw-1:0] incOf(input int ch, input int val);
    logic [Ch*Iw-1:0] v;
    v = '0;
    v[ch*Iw +: Iw] = Iw'(val);
    return v;
  endfunction

  task automatic applyStimulus(input logic [Ch*Iw-1:0] inc, input bit en, input bit clr,
                               input bit dreq, input bit rdy, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      eventInc  = inc;
      enable    = en;
      clear     = clr && (i == 0);
      dumpReq   = dreq && (i == 0);
      dumpReady = rdy;
    end
  endtask

  bit found;

  initial begin
    #12;
    for (int m = 0; m < 2; m++) begin
      checkOutput({nm[m], ".rstValid"}, dumpValid[m], 0);
      checkOutput({nm[m], ".rstBusy"}, busy[m], 0);
      checkOutput({nm[m], ".rstId"}, dumpId[m], 0);
      checkOutput({nm[m], ".rstData"}, dumpData[m], 0);
      checkOutput({nm[m], ".rstLast"}, dumpLast[m], 0);
      checkOutput({nm[m], ".rstDrop"}, snapDrop[m], 0);
    end
    @(negedge clk);
    rst = 1'b1;

    $display("[TB] basic counting and manual dump");
    applyStimulus(incOf(0, 3) | incOf(5, 1), 1, 0, 0, 1, 10);
    applyStimulus(incOf(0, 3) | incOf(5, 1), 1, 0, 1, 1, 1);
    applyStimulus('0, 1, 0, 0, 1, 12);

    $display("[TB] overflow: saturate vs wrap");
    applyStimulus(incOf(1, 7), 1, 0, 0, 1, 40);
    applyStimulus('0, 1, 0, 1, 1, 12);

    $display("[TB] sampling window with enable gap");
    applyStimulus('0, 1, 1, 0, 1, 1);
    windowCfg = 16'd100;
    applyStimulus(incOf(2, 1), 1, 0, 0, 1, 230);
    applyStimulus(incOf(2, 1), 0, 0, 0, 1, 20);
    applyStimulus(incOf(2, 1), 1, 0, 0, 1, 100);
    windowCfg = 16'd0;
    applyStimulus('0, 1, 1, 0, 1, 12);

    $display("[TB] stall on beat 3 with dropped request");
    applyStimulus(incOf(4, 2), 1, 0, 1, 1, 1);
    applyStimulus(incOf(4, 2), 1, 0, 0, 1, 3);
    applyStimulus(incOf(4, 2), 1, 0, 0, 0, 1);
    applyStimulus(incOf(4, 2), 1, 0, 1, 0, 4);
    applyStimulus('0, 1, 0, 0, 1, 12);

    $display("[TB] clear together with dump request");
    applyStimulus('0, 1, 1, 0, 1, 1);
    applyStimulus(incOf(0, 5), 1, 0, 0, 1, 10);
    applyStimulus(incOf(0, 5), 1, 1, 1, 1, 1);
    applyStimulus('0, 1, 0, 0, 1, 12);
    applyStimulus('0, 1, 0, 1, 1, 1);
    applyStimulus('0, 1, 0, 0, 1, 12);

    $display("[TB] randomised traffic");
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      eventInc  = Ch*Iw'($urandom);
      enable    = ($urandom_range(0, 9) != 0);
      clear     = ($urandom_range(0, 49) == 0);
      dumpReq   = ($urandom_range(0, 24) == 0);
      dumpReady = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0)
        windowCfg = ($urandom_range(0, 2) == 0) ? 16'd0 : Ww'($urandom_range(1, 40));
    end
    windowCfg = 16'd0;
    applyStimulus('0, 1, 0, 0, 1, 12);

    $display("[TB] asynchronous reset during a dump");
    applyStimulus(incOf(3, 6), 1, 0, 1, 1, 1);
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(negedge clk);
      dumpReq = 1'b0;
      if (dumpValid[0] && dumpId[0] == 3'd4) found = 1'b1;
    end
    checkOutput("waitBeat4", found, 1);
    #2 rst = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      checkOutput({nm[m], ".asyncValid"}, dumpValid[m], 0);
      checkOutput({nm[m], ".asyncBusy"}, busy[m], 0);
    end
    @(negedge clk);
    rst = 1'b1;
    applyStimulus('0, 1, 0, 1, 1, 1);
    applyStimulus('0, 1, 0, 0, 1, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/perf_event_counter_bank.md
Name: perf_event_counter_bank

Overview:
- Parametrised bank of hardware performance-event counters. Generalises the single-event, fixed 32-bit, always-counting perf counter to multi-channel, multi-event-per-cycle counting.
- Adds optional periodic sampling windows, saturate/wrap modes and sticky overflow flags.
- Snapshots are serialised out over a valid/ready stream, so counters can be read in synthesis and not only in simulation.
- Sits beside the pipeline; event sources (commit, caches, predictors) drive per-channel increment inputs.

Parameters:
- CHANNELS, 8, number of independent counters (>=1).
- CNT_WIDTH, 32, bits per counter (>= INC_WIDTH).
- INC_WIDTH, 3, bits of per-channel per-cycle increment (up to 2^INC_WIDTH-1 events per cycle).
- WINDOW_WIDTH, 16, width of the sampling-window length/counter.
- SATURATE, 1, 1 = counters saturate at all-ones; 0 = counters wrap modulo 2^CNT_WIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- event_inc  in  CHANNELS*INC_WIDTH  per-channel increment; channel i is bits [i*INC_WIDTH +: INC_WIDTH].
- enable  in  1  counting enable; 0 freezes live counters and the window counter.
- clear  in  1  synchronous zeroing of live counters, overflow flags and window counter.
- window_cfg  in  WINDOW_WIDTH  window length in enabled cycles; 0 = windowing off.
- dump_req  in  1  manual snapshot-and-dump request (one-cycle pulse).
- dump_valid  out  1  dump beat valid.
- dump_ready  in  1  consumer accepts beat.
- dump_id  out  max(1,$clog2(CHANNELS))  channel index of the current beat.
- dump_data  out  CNT_WIDTH  snapshotted counter value.
- dump_ovf  out  1  snapshotted overflow flag of that channel.
- dump_last  out  1  beat is channel CHANNELS-1.
- busy  out  1  dump in progress.
- snap_drop  out  1  one-cycle pulse: a snapshot trigger was ignored because busy.

Behaviour:
- Reset (rst=0, async):
  - all live counters, shadow counters, overflow flags and window_cnt = 0;
  - FSM = IDLE;
  - dump_valid = busy = dump_last = snap_drop = 0;
  - dump_id = 0, dump_data = 0, dump_ovf = 0.
- Counting: when enable=1, next_i = cnt_i + event_inc_i (INC_WIDTH zero-extended to CNT_WIDTH+1 bits).
  - If the carry bit is set:
    - SATURATE=1: cnt_i = all-ones;
    - SATURATE=0: cnt_i = low CNT_WIDTH bits;
    - in both modes ovf_i is set and stays set until clear or a window restart.
  - When enable=0: counters, flags and window_cnt hold; event_inc is ignored.
- Window:
  - When enable=1 and window_cfg != 0, window_cnt increments.
  - When window_cnt == window_cfg-1 in an enabled cycle, a window boundary fires:
    - trigger a snapshot;
    - live counters, ovf flags and window_cnt load 0 next cycle.
  - window_cfg changed mid-window: compare against the new value. If window_cnt >= window_cfg-1, the boundary fires on the next enabled cycle.
- Snapshot trigger = window boundary OR dump_req.
  - Shadow_i captures next_i, i.e. including this cycle's increment and saturation/wrap result.
  - Shadow ovf captures the updated ovf_i.
  - dump_req does not clear the live counters.
- FSM:
  - IDLE: on a snapshot trigger, capture shadows, idx = 0, go to DUMP.
  - DUMP:
    - dump_valid = 1, dump_id = idx, dump_data = shadow[idx], dump_ovf = shadow_ovf[idx], dump_last = (idx == CHANNELS-1), busy = 1.
    - On dump_valid && dump_ready: idx++; if dump_last, go to IDLE.
  - Outputs are registered; the first beat is valid the cycle after the trigger.
  - dump_data/dump_id hold stable while valid && !ready.
- Trigger while busy, or on the cycle the last beat is accepted:
  - shadows are not overwritten; snap_drop pulses next cycle.
  - A window boundary still clears the live counters, so that window's data is lost by design.
- Simultaneous events:
  - clear has priority over increment and over a window-boundary reset; live state is 0 next cycle.
  - A snapshot triggered in the same cycle as clear still captures next_i (pre-clear).
  - clear does not affect an in-progress dump or the shadow registers.
- Back-to-back: a trigger in the first IDLE cycle after DUMP is accepted normally.
- CHANNELS=1: dump_id is constant 0 and dump_last = 1 on every beat.

Test Plan:
- Reset, enable=1, event_inc ch0=3, ch5=1 for 10 cycles, then dump_req -> with dump_ready=1, 8 beats starting the next cycle; ch0=30 (if dump_req cycle still incrementing: 33), ch5=11/10 accordingly, others 0, dump_last only on id 7.
- SATURATE=1, CNT_WIDTH=8, ch1 inc=7 for 40 cycles -> dump shows 0xFF with ovf=1. Same with SATURATE=0 -> value (280 mod 256)=24 with ovf=1.
- window_cfg=100, ch2 inc=1 constant -> auto dump every 100 enabled cycles, each showing ch2=100, ovf=0. Toggling enable=0 for 20 cycles stretches the period to 120 wall cycles.
- dump_ready held 0 for 5 cycles during beat 3 -> dump_id/dump_data stable. A dump_req during that stall -> snap_drop pulse, shadows unchanged.
- clear asserted with dump_req in the same cycle, ch0=50 before -> dumped ch0 = 50+inc; live ch0 reads 0 on the next dump.
- rst deasserted-then-asserted mid-DUMP at beat 4 -> dump_valid=0, busy=0 immediately, all counters 0 after release.
